// File: rtl/lpif_tx_half_packer_ctrl.sv
// Packs LPIF lane beats into two-lane TX FIFO words. Gen2 pairs beats. Gen1 and flushes emit
// lane 0 only. A single output slot register decouples the packer from FIFO backpressure.
module lpif_tx_half_packer_ctrl #(
  parameter int unsigned FLUSH_TIMEOUT = 8
) (
  input  logic         clk_wr,
  input  logic         rst_wr_n,
  input  logic         m_gen2_mode,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [74:0]  s_beat,
  input  logic         flush_req,
  output logic [149:0] txfifo_downstream_data,
  output logic         txfifo_push,
  input  logic         txfifo_full,
  output logic         half_pending,
  output logic [15:0]  flush_cnt
);

  localparam logic [7:0] CntMax = 8'(FLUSH_TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StHalf} state_e;

  state_e         state_q, state_d;
  logic           out_vld_q, out_vld_d;
  logic [149:0]   out_word_q, out_word_d;
  logic [74:0]    hold_q, hold_d;
  logic [7:0]     idle_cnt_q, idle_cnt_d;
  logic [15:0]    flush_cnt_q, flush_cnt_d;
  logic           slot_avail;
  logic           mode_flush;
  logic           accept;
  logic           flush_single;

  assign txfifo_push            = out_vld_q & ~txfifo_full;
  assign slot_avail             = ~out_vld_q | txfifo_push;
  assign mode_flush             = (state_q == StHalf) & ~m_gen2_mode;
  assign s_ready                = slot_avail & ~mode_flush;
  assign accept                 = s_valid & s_ready;
  assign txfifo_downstream_data = out_word_q;
  assign half_pending           = (state_q == StHalf);
  assign flush_cnt              = flush_cnt_q;

  always_comb begin
    state_d      = state_q;
    out_vld_d    = out_vld_q & ~txfifo_push;
    out_word_d   = out_word_q;
    hold_d       = hold_q;
    idle_cnt_d   = idle_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    flush_single = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (m_gen2_mode) begin
            hold_d     = s_beat;
            idle_cnt_d = '0;
            state_d    = StHalf;
          end else begin
            out_vld_d  = 1'b1;
            out_word_d = {75'b0, s_beat};
          end
        end
      end
      StHalf: begin
        // A partner beat always wins over any flush condition in the same cycle.
        if (accept) begin
          out_vld_d  = 1'b1;
          out_word_d = {s_beat, hold_q};
          state_d    = StIdle;
        end else if (slot_avail && (mode_flush || flush_req || idle_cnt_q == CntMax)) begin
          flush_single = 1'b1;
          out_vld_d    = 1'b1;
          out_word_d   = {75'b0, hold_q};
          state_d      = StIdle;
        end else if (idle_cnt_q != CntMax) begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush_single && flush_cnt_q != 16'hFFFF) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q     <= StIdle;
      out_vld_q   <= 1'b0;
      out_word_q  <= '0;
      hold_q      <= '0;
      idle_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_vld_q   <= out_vld_d;
      out_word_q  <= out_word_d;
      hold_q      <= hold_d;
      idle_cnt_q  <= idle_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_lpif_tx_half_packer_ctrl.sv
// Directed bench for lpif_tx_half_packer_ctrl: vector table plus timeout and async-reset sequences.
module tb_lpif_tx_half_packer_ctrl;

  logic         clk_wr = 1'b0;
  logic         rst_wr_n = 1'b0;
  logic         m_gen2_mode = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [74:0]  s_beat = '0;
  logic         flush_req = 1'b0;
  logic [149:0] txfifo_downstream_data;
  logic         txfifo_push;
  logic         txfifo_full = 1'b0;
  logic         half_pending;
  logic [15:0]  flush_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [74:0] BA = 75'h0123456789ABCDEF0A1;
  localparam logic [74:0] BB = 75'h7EDCBA9876543210F5E;
  localparam logic [74:0] BC = 75'h2A5A5A5A5A5A5A5A5C3;
  localparam logic [74:0] BD = 75'h3000000000000000001;
  localparam logic [74:0] Z  = 75'h0;

  lpif_tx_half_packer_ctrl #(.FLUSH_TIMEOUT(8)) dut (
    .clk_wr                 (clk_wr),
    .rst_wr_n               (rst_wr_n),
    .m_gen2_mode            (m_gen2_mode),
    .s_valid                (s_valid),
    .s_ready                (s_ready),
    .s_beat                 (s_beat),
    .flush_req              (flush_req),
    .txfifo_downstream_data (txfifo_downstream_data),
    .txfifo_push            (txfifo_push),
    .txfifo_full            (txfifo_full),
    .half_pending           (half_pending),
    .flush_cnt              (flush_cnt)
  );

  always #5 clk_wr = ~clk_wr;

  typedef struct {
    logic         g2;
    logic         vld;
    logic [74:0]  beat;
    logic         fr;
    logic         full;
    logic         rdy;
    logic         push;
    logic [149:0] data;
    logic         half;
    logic [15:0]  fcnt;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mkv(input logic g2, input logic vld, input logic [74:0] beat,
                               input logic fr, input logic full, input logic rdy,
                               input logic push, input logic [149:0] data, input logic half,
                               input logic [15:0] fcnt);
    vec_t v;
    v.g2 = g2; v.vld = vld; v.beat = beat; v.fr = fr; v.full = full;
    v.rdy = rdy; v.push = push; v.data = data; v.half = half; v.fcnt = fcnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [149:0] act, input logic [149:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check outputs before the next rising edge.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk_wr);
    m_gen2_mode = v.g2;
    s_valid     = v.vld;
    s_beat      = v.beat;
    flush_req   = v.fr;
    txfifo_full = v.full;
    #1;
    chk({tag, ".s_ready"}, 150'(s_ready), 150'(v.rdy));
    chk({tag, ".push"}, 150'(txfifo_push), 150'(v.push));
    chk({tag, ".data"}, txfifo_downstream_data, v.data);
    chk({tag, ".half"}, 150'(half_pending), 150'(v.half));
    chk({tag, ".flush_cnt"}, 150'(flush_cnt), 150'(v.fcnt));
  endtask

  initial begin
    //                g2 v  beat fr full rdy push data          half fcnt
    vecs[0]  = mkv(1, 0, Z,  0, 0, 1, 0, '0,          0, 0);
    vecs[1]  = mkv(1, 1, BA, 0, 0, 1, 0, '0,          0, 0);
    vecs[2]  = mkv(1, 1, BB, 0, 0, 1, 0, '0,          1, 0);
    vecs[3]  = mkv(1, 0, Z,  0, 0, 1, 1, {BB, BA},    0, 0);
    vecs[4]  = mkv(1, 0, Z,  1, 0, 1, 0, {BB, BA},    0, 0);
    vecs[5]  = mkv(1, 1, BC, 0, 0, 1, 0, {BB, BA},    0, 0);
    vecs[6]  = mkv(1, 1, BD, 1, 0, 1, 0, {BB, BA},    1, 0);
    vecs[7]  = mkv(1, 1, BA, 0, 1, 0, 0, {BD, BC},    0, 0);
    vecs[8]  = mkv(1, 1, BA, 0, 1, 0, 0, {BD, BC},    0, 0);
    vecs[9]  = mkv(1, 1, BA, 0, 0, 1, 1, {BD, BC},    0, 0);
    vecs[10] = mkv(1, 0, Z,  1, 0, 1, 0, {BD, BC},    1, 0);
    vecs[11] = mkv(1, 0, Z,  0, 0, 1, 1, {Z, BA},     0, 1);
    vecs[12] = mkv(1, 1, BB, 0, 0, 1, 0, {Z, BA},     0, 1);
    vecs[13] = mkv(0, 1, BC, 0, 0, 0, 0, {Z, BA},     1, 1);
    vecs[14] = mkv(0, 1, BC, 0, 0, 1, 1, {Z, BB},     0, 2);
    vecs[15] = mkv(0, 0, Z,  0, 0, 1, 1, {Z, BC},     0, 2);
    vecs[16] = mkv(0, 0, Z,  0, 0, 1, 0, {Z, BC},     0, 2);

    // Outputs while reset is held, before any clock edge matters.
    #2;
    chk("rst.push", 150'(txfifo_push), 150'(0));
    chk("rst.half", 150'(half_pending), 150'(0));
    chk("rst.s_ready", 150'(s_ready), 150'(1));
    chk("rst.data", txfifo_downstream_data, '0);
    chk("rst.flush_cnt", 150'(flush_cnt), 150'(0));
    @(negedge clk_wr);
    @(negedge clk_wr);
    rst_wr_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Timeout flush: accept A, eight counting cycles, push on the ninth.
    apply(mkv(1, 1, BA, 0, 0, 1, 0, {Z, BC}, 0, 2), "to.accept");
    for (int n = 1; n <= 8; n++) begin
      apply(mkv(1, 0, Z, 0, 0, 1, 0, {Z, BC}, 1, 2), $sformatf("to.wait%0d", n));
    end
    apply(mkv(1, 0, Z, 0, 0, 1, 1, {Z, BA}, 0, 3), "to.push");

    // Async reset while a beat is held.
    apply(mkv(1, 1, BB, 0, 0, 1, 0, {Z, BA}, 0, 3), "ar1.accept");
    @(negedge clk_wr);
    s_valid = 1'b0;
    #1;
    chk("ar1.pre_half", 150'(half_pending), 150'(1));
    rst_wr_n = 1'b0;
    #1;
    chk("ar1.half", 150'(half_pending), 150'(0));
    chk("ar1.push", 150'(txfifo_push), 150'(0));
    chk("ar1.s_ready", 150'(s_ready), 150'(1));
    chk("ar1.flush_cnt", 150'(flush_cnt), 150'(0));
    @(negedge clk_wr);
    rst_wr_n = 1'b1;

    // Async reset while a paired word is being pushed: the word is discarded.
    apply(mkv(1, 1, BC, 0, 0, 1, 0, '0, 0, 0), "ar2.a");
    apply(mkv(1, 1, BD, 0, 0, 1, 0, '0, 1, 0), "ar2.b");
    @(negedge clk_wr);
    s_valid = 1'b0;
    #1;
    chk("ar2.pre_push", 150'(txfifo_push), 150'(1));
    rst_wr_n = 1'b0;
    #1;
    chk("ar2.push", 150'(txfifo_push), 150'(0));
    chk("ar2.data", txfifo_downstream_data, '0);
    @(negedge clk_wr);
    rst_wr_n = 1'b1;
    apply(mkv(1, 0, Z, 0, 0, 1, 0, '0, 0, 0), "ar2.after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lpif_tx_half_packer_ctrl.md
LPIF_TX_HALF_PACKER_CTRL -- requirements
Module: lpif_tx_half_packer_ctrl

Interface
REQ-001 Parameter FLUSH_TIMEOUT, default 8: idle cycles a held lane-0 beat waits for a partner before a single-lane flush; legal range 2..255.
REQ-002 clk_wr  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_wr_n  in  1  reset, asynchronous and active-low.
REQ-004 m_gen2_mode  in  1  1 = pack two beats per word; 0 = one beat per word, lane 0 only.
REQ-005 s_valid  in  1  upstream beat valid.
REQ-006 s_ready  out  1  upstream beat accepted when s_valid & s_ready.
REQ-007 s_beat  in  75  one LPIF lane beat: [0+:4] state, [4+:2] protid, [6+:64] data, [70] dvalid, [71+:2] crc, [73] crc_valid, [74] valid.
REQ-008 flush_req  in  1  single-cycle pulse forcing immediate emission of a held beat.
REQ-009 txfifo_downstream_data  out  150  packed word: lane 0 in [0+:75], lane 1 in [75+:75].
REQ-010 txfifo_push  out  1  word written to TX FIFO this cycle.
REQ-011 txfifo_full  in  1  TX FIFO cannot accept a word.
REQ-012 half_pending  out  1  a lane-0 beat is held (state HALF).
REQ-013 flush_cnt  out  16  count of single-lane words emitted in gen2 mode, saturating at 16'hFFFF.

Function
REQ-014 Output slot: one-entry register (out_vld, out_word); txfifo_downstream_data = out_word.
REQ-015 txfifo_push = out_vld & ~txfifo_full; out_vld clears on push unless the slot is reloaded in the same cycle.
REQ-016 slot_avail = ~out_vld | txfifo_push; no word is loaded into the slot unless slot_avail.
REQ-017 s_ready = slot_avail & ~mode_flush, where mode_flush = (state==HALF) & ~m_gen2_mode.
REQ-018 States: IDLE (no beat held) and HALF (beat held in 75-bit hold_reg).
REQ-019 Gen1, IDLE: an accepted beat loads out_word = {75'b0, s_beat}; the beat appears on the FIFO interface the next cycle; state stays IDLE.
REQ-020 Gen2, IDLE: an accepted beat is captured in hold_reg; idle counter clears to 0; state -> HALF.
REQ-021 Gen2, HALF: an accepted beat loads out_word = {s_beat, hold_reg}; state -> IDLE.
REQ-022 HALF with no beat accepted: idle counter increments by 1 per cycle, saturating at FLUSH_TIMEOUT-1.
REQ-023 Timeout flush: in HALF, with idle counter == FLUSH_TIMEOUT-1, slot_avail, and no beat accepted, the slot loads {75'b0, hold_reg}; state -> IDLE; flush_cnt increments.
REQ-024 flush_req in HALF with slot_avail and no beat accepted: same action as REQ-023, regardless of the counter value.
REQ-025 Simultaneous beat and flush condition in HALF: the beat pairs per REQ-021; flush_cnt does not increment.
REQ-026 flush_req in IDLE: no effect.
REQ-027 mode_flush: a held beat is emitted lane-0-only on the first slot_avail cycle; flush_cnt increments; state -> IDLE; no beat is accepted in that cycle.
REQ-028 Backpressure: while ~slot_avail, hold_reg, out_word, and state are held; the idle counter keeps saturating.
REQ-029 Beat content is not interpreted; s_beat[74] = 0 is still packed as a beat.

Reset
REQ-030 While rst_wr_n = 0, the following SHALL hold: state = IDLE; out_vld = 0; out_word = 0; hold_reg = 0; idle counter = 0; flush_cnt = 0.
REQ-031 Resulting outputs during reset: txfifo_push = 0; half_pending = 0; s_ready = 1; txfifo_downstream_data = 0.
REQ-032 Reset asserted mid-operation discards any held or slotted beat without pushing it.

Verification
REQ-033 Gen2 pairing:
- Stimulus: beats A, B on consecutive cycles; txfifo_full = 0.
- Response: one push of {B, A} one cycle after B is accepted; flush_cnt = 0.
REQ-034 Gen2 timeout:
- Stimulus: FLUSH_TIMEOUT = 8; single beat A, then idle.
- Response: push of {0, A} 9 cycles after acceptance (8 counting cycles plus the slot cycle); flush_cnt = 1.
REQ-035 Backpressure:
- Stimulus: txfifo_full = 1 with a word slotted.
- Response: s_ready = 0 and the word is held stable.
- Stimulus: txfifo_full drops.
- Response: push in that cycle; s_ready = 1 in the same cycle.
REQ-036 Mode change mid-pair:
- Stimulus: beat A held; m_gen2_mode -> 0.
- Response: s_ready = 0 for one cycle; push of {0, A}; next beat C is pushed as {0, C}.
REQ-037 Flush collision:
- Stimulus: flush_req and beat B in the same cycle while A is held.
- Response: push of {B, A}; flush_cnt unchanged.
REQ-038 Async reset:
- Stimulus: rst_wr_n low while in HALF with out_vld = 1.
- Response: txfifo_push = 0 and half_pending = 0 immediately, with no clock edge required.
